// File: rtl/ff_sched_pkg.sv
// Shared types and drive-code helpers for the time-multiplexed flip-flop cell scheduler.
package ff_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    EXEC    = 2'd2,
    CAPTURE = 2'd3
  } sched_state_e;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_TGL = 2'b01;
  localparam logic [1:0] OP_SET = 2'b11;

  // The cell has no hold code; feeding q on both inputs reproduces q.
  function automatic logic [1:0] hold_code(input logic q);
    return {q, q};
  endfunction

  function automatic logic [1:0] restore_code(input logic b);
    return b ? OP_SET : OP_CLR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest index at or above ptr wins, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/ff_cell_scheduler.sv
// Shares one registered logic cell among NUM_REQ requesters, each owning a virtual 1-bit register.
module ff_cell_scheduler
  import ff_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][1:0] req_op,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic                    rsp_q,
  output logic [1:0]              cell_entrada,
  output logic                    cell_reset,
  input  logic                    cell_q
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e        state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [1:0]          op_q, op_d;
  logic [NUM_REQ-1:0]  ctx_q, ctx_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign cell_reset = ~reset_n;

  // Response is a pure decode of CAPTURE; cell_q already holds the executed result.
  always_comb begin
    rsp_valid = '0;
    rsp_q     = 1'b0;
    if (reset_n && state_q == CAPTURE) begin
      rsp_valid        = NUM_REQ'(1) << win_q;
      rsp_q            = cell_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    owner_d      = owner_q;
    op_d         = op_q;
    ctx_d        = ctx_q;
    req_ready    = '0;
    cell_entrada = hold_code(cell_q);
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = reset_n ? gnt : '0;
          win_d     = gnt_idx;
          op_d      = req_op[gnt_idx];
          ptr_d     = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
          state_d   = (gnt_idx == owner_q) ? EXEC : RESTORE;
        end
      end
      RESTORE: begin
        cell_entrada = restore_code(ctx_q[win_q]);
        owner_d      = win_q;
        state_d      = EXEC;
      end
      EXEC: begin
        cell_entrada = op_q;
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        ctx_d[win_q] = cell_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      owner_q <= '0;
      op_q    <= OP_CLR;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      ctx_q   <= ctx_d;
    end
  end

endmodule

// File: tb/tb_ff_cell_scheduler.sv
// Scoreboard bench: models the cell and virtual contexts, checks grants, restore drives and responses.
module tb_ff_cell_scheduler;
  import ff_sched_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0][1:0] req_op = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic              rsp_q;
  logic [1:0]        cell_entrada;
  logic              cell_reset;
  logic              cell_q = 1'b0;

  ff_cell_scheduler #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_q        (rsp_q),
    .cell_entrada (cell_entrada),
    .cell_reset   (cell_reset),
    .cell_q       (cell_q)
  );

  always #5 clk = ~clk;

  // Reference cell: d = (e0&e1) | (~q&e0), synchronous active-high reset.
  always @(posedge clk) begin
    if (cell_reset) cell_q <= 1'b0;
    else            cell_q <= (cell_entrada[0] & cell_entrada[1]) | (~cell_q & cell_entrada[0]);
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int   idx;
    logic q;
    int   due;
  } exp_t;

  exp_t         sb[$];
  int           glog[$];
  logic [N-1:0] m_ctx = '0;
  int           m_owner = 0;
  logic         rst_pend = 1'b0;
  logic [1:0]   rst_exp = 2'b00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_cell_reset", 32'(cell_reset), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      sb.delete();
      m_ctx    = '0;
      m_owner  = 0;
      rst_pend = 1'b0;
    end else begin
      if (rst_pend) begin
        chk("restore_code", 32'(cell_entrada), 32'(rst_exp));
        rst_pend = 1'b0;
      end
      if (req_ready != '0) begin
        int   i;
        logic res;
        exp_t e;
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        i = 0;
        for (int k = N - 1; k >= 0; k--) if (req_ready[k]) i = k;
        case (req_op[i])
          2'b01:   res = ~m_ctx[i];
          2'b11:   res = 1'b1;
          default: res = 1'b0;
        endcase
        if (i != m_owner) begin
          rst_pend = 1'b1;
          rst_exp  = m_ctx[i] ? 2'b11 : 2'b00;
        end
        e.idx = i;
        e.q   = res;
        e.due = cyc + ((i != m_owner) ? 3 : 2);
        sb.push_back(e);
        glog.push_back(i);
        m_ctx[i] = res;
        m_owner  = i;
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_who", 32'(rsp_valid), 32'(N'(1) << e.idx));
          chk("rsp_q", 32'(rsp_q), 32'(e.q));
          chk("rsp_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic send(input int i, input logic [1:0] op);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 32'(i), 32'hFFFF);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int l;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("init_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("init_rsp_q", 32'(rsp_q), 32'd0);
    chk("init_entrada", 32'(cell_entrada), 32'd0);

    // same-owner SET, then owner switch with restore 00, then restore 11
    send(0, OP_SET); drain();
    send(1, OP_TGL); drain();
    send(0, OP_TGL); drain();
    send(0, 2'b10);  drain();

    // idle with cell holding 1
    send(0, OP_SET); drain();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_hold", 32'(cell_entrada), 32'h3);
      chk("idle_q", 32'(cell_q), 32'd1);
    end

    // reset while the accepted op is in EXEC
    send(0, OP_TGL);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_entrada", 32'(cell_entrada), 32'd0);
    send(1, OP_TGL); drain();
    send(0, OP_TGL); drain();

    // pointer now 1: grant 2 moves it to 3, then 1 and 2 contend
    send(2, OP_SET); drain();
    l = glog.size();
    fork
      send(1, OP_TGL);
      send(2, OP_TGL);
    join
    drain();
    chk("wrap_first", 32'(glog[l]), 32'd1);
    chk("wrap_second", 32'(glog[l+1]), 32'd2);

    // pointer at 3 again: continuous 0/1 requests alternate
    l = glog.size();
    fork
      begin send(0, OP_TGL); send(0, OP_SET); end
      begin send(1, OP_SET); send(1, OP_TGL); end
    join
    drain();
    chk("alt_0", 32'(glog[l]),   32'd0);
    chk("alt_1", 32'(glog[l+1]), 32'd1);
    chk("alt_2", 32'(glog[l+2]), 32'd0);
    chk("alt_3", 32'(glog[l+3]), 32'd1);

    // mixed traffic on all requesters
    fork
      begin send(0, OP_TGL); send(0, OP_CLR); end
      begin send(1, OP_TGL); send(1, OP_TGL); end
      begin send(2, 2'b10); send(2, OP_SET); end
      begin send(3, OP_SET); send(3, OP_TGL); end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
